wbuf_pingpong: RTL
==================

# wbuf_pingpong

Double-buffered weight buffer feeding the systolic PE array. It holds two banks of DEPTH weight words. The loader fills one bank while the array drains the other, so weight loading overlaps compute. This block is the multi-entry successor of the single-register weight buffer and adds fill/drain handshakes with backpressure.

## Interface
- ARRAY_SIZE, 4: PE array dimension; sets DEPTH default.
- DATA_W, 32: weight word width.
- DEPTH, ARRAY_SIZE*ARRAY_SIZE: entries per bank; must be ≥2.
- LEN_W, $clog2(DEPTH+1): width of stored tile length.

Ports:
- clk  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- wr_en  in  1  write request for one word.
- wr_data  in  DATA_W  word to write.
- wr_last  in  1  marks the final word of a tile; qualified by wr_en.
- wr_ready  out  1  fill bank can accept a word.
- rd_start  in  1  request to drain the oldest full bank.
- rd_hold  in  1  consumer stall; freezes the read stream.
- rd_valid  out  1  rd_data holds a valid word.
- rd_data  out  DATA_W  weight word output, registered.
- rd_last  out  1  rd_data is the final word of the tile.
- full_cnt  out  2  number of banks that are FULL or DRAINING (0..2).
- rd_reuse  in  1  present only with WBUF_REUSE_EN.

## Operation
- Each bank has a state (EMPTY, FILLING, FULL, DRAINING) and a length `len[LEN_W]`.
- Two 1-bit selectors, `fill_sel` and `drain_sel`, pick the banks. Both toggle independently, so tiles drain in fill order.
- Write side:
  - A write is accepted when wr_en && wr_ready. wr_ready = fill bank is EMPTY or FILLING.
  - An accepted word goes to `mem[fill_sel][wptr]`, then wptr increments. The bank enters FILLING.
  - The tile closes on wr_last, or when wptr==DEPTH-1 (implicit last). On close: len=wptr+1, bank goes FULL, fill_sel toggles, wptr=0.
  - wr_en while wr_ready=0 is dropped, with no state change.
- Read side, with an FSM of IDLE and STREAM:
  - In IDLE, rd_start is accepted if `bank[drain_sel]` is FULL. The bank goes DRAINING, rptr=0, and the FSM goes to STREAM.
  - rd_start is ignored if the drain bank is not FULL, or while in STREAM.
  - In STREAM, rd_data/rd_valid present `mem[drain_sel][rptr]`. A word retires on a cycle with rd_valid=1 and rd_hold=0, and rptr increments.
  - rd_last = rd_valid && rptr==len-1.
  - When the last word retires: bank goes EMPTY, drain_sel toggles, FSM returns to IDLE, rd_valid=0 next cycle.
- Fill and drain never target the same bank. When a tile closes and a drain finishes in the same cycle, both updates apply.
- full_cnt counts FULL+DRAINING banks after each edge.

## Timing
- Reset values: rd_valid=0, rd_last=0, rd_data=0, full_cnt=0, wr_ready=1. Both banks EMPTY, selectors=0, pointers=0, FSM=IDLE. Memory contents are not reset.
- A reset asserted mid-operation discards all tiles and stream state immediately (asynchronous).
- wr_ready reflects the closing write on the next cycle. If the other bank is FULL or DRAINING, wr_ready=0 the cycle after the close.
- Read latency: rd_start accepted at edge N gives rd_valid=1 with word 0 after edge N+1.
- Throughput is one word per cycle without hold. Hold cycles keep rd_data, rd_valid and rd_last stable.
- A tile is drainable the cycle after its closing write, so rd_start in that cycle is accepted.
- Minimum gap between streams is one IDLE cycle.

## Configuration
- WBUF_REUSE_EN defined: the rd_reuse input exists. If rd_reuse=1 when the last word retires, the bank returns to FULL instead of EMPTY, keeping its len. drain_sel does not toggle, and the same tile can be re-streamed.
- WBUF_REUSE_EN undefined: the port is absent. A drained bank always becomes EMPTY.

## Test plan
- Reset then idle: all outputs at reset values, wr_ready=1, full_cnt=0. rd_start is ignored, with rd_valid staying 0.
- DEPTH=16: write 16 words 0x100..0x10F without wr_last, then rd_start → bank closes implicitly. 16 valid words 0x100..0x10F stream back to back; rd_last is on 0x10F; full_cnt goes 1→0.
- Ping-pong: fill tile A (4 words, wr_last on 4th) then tile B (3 words). Drain A while writing tile C → A streams 4 words with rd_last on word 4. wr_ready drops after B closes and rises the cycle after A empties; C lands in A's bank.
- Backpressure: rd_hold=1 for 3 cycles on word 2 of a 5-word tile → rd_data/rd_last stay stable across the hold. The tile completes with exactly 5 retirements.
- Boundary: single-word tile (wr_last on first write) → len=1; drain gives one word with rd_valid=rd_last=1. Assert nRST mid-stream → outputs go to reset values the same cycle, and a subsequent rd_start is ignored.
- With WBUF_REUSE_EN: drain a 3-word tile with rd_reuse=1, then rd_start again → identical 3 words repeat and full_cnt stays 1. A third drain with rd_reuse=0 gives full_cnt=0.

Source files
------------

// File: rtl/wbuf_pingpong_if.sv
// wbuf_pingpong_if
//   Fill/drain bus of the ping-pong weight buffer.
//   Ports (slave = buffer side):
//     wr_en, wr_data, wr_last  -> write one word, mark end of tile
//     wr_ready                 <- fill bank can take a word
//     rd_start, rd_hold        -> start draining oldest full bank, stall stream
//     rd_valid, rd_data, rd_last <- registered read stream
//     full_cnt                 <- banks holding a closed tile (0..2)
//     rd_reuse                 -> keep drained tile (only with WBUF_REUSE_EN)
//   Macro: WBUF_REUSE_EN adds rd_reuse.
interface wbuf_pingpong_if #(
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              wr_ready;
  logic              rd_start;
  logic              rd_hold;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic [1:0]        full_cnt;
`ifdef WBUF_REUSE_EN
  logic              rd_reuse;
`endif

  modport master (
    output wr_en, wr_data, wr_last, rd_start, rd_hold,
    input  wr_ready, rd_valid, rd_data, rd_last, full_cnt
`ifdef WBUF_REUSE_EN
    , output rd_reuse
`endif
  );

  modport slave (
    input  wr_en, wr_data, wr_last, rd_start, rd_hold,
    output wr_ready, rd_valid, rd_data, rd_last, full_cnt
`ifdef WBUF_REUSE_EN
    , input rd_reuse
`endif
  );
endinterface

// File: rtl/wbuf_pingpong.sv
// wbuf_pingpong
//   Double-buffered weight buffer: the loader fills one bank while the PE
//   array drains the other. Tiles drain in the order they were filled.
//   Ports:
//     clk   system clock, rising edge
//     nRST  asynchronous active-low reset
//     bus   wbuf_pingpong_if.slave (write side, read stream, full_cnt)
//   Macro: WBUF_REUSE_EN -- when defined, rd_reuse=1 at the final retirement
//   returns the bank to FULL so the same tile can be streamed again.
//
//   Read FSM:
//     state     | meaning
//     RD_IDLE   | no stream; waiting for rd_start with drain bank FULL
//     RD_STREAM | drain bank presented one word per cycle on rd_data
module wbuf_pingpong #(
  parameter int ARRAY_SIZE = 4,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = ARRAY_SIZE * ARRAY_SIZE,
  parameter int LEN_W      = $clog2(DEPTH + 1)
) (
  input logic            clk,
  input logic            nRST,
  wbuf_pingpong_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
  typedef enum logic {RD_IDLE, RD_STREAM} rd_st_e;

  bank_st_e          bank_q [2];
  bank_st_e          bank_d [2];
  logic [LEN_W-1:0]  len_q  [2];
  logic [LEN_W-1:0]  len_d  [2];
  logic              fill_sel_q, fill_sel_d;
  logic              drain_sel_q, drain_sel_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  rd_st_e            rd_st_q, rd_st_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] mem_q [2][DEPTH];

  logic       wr_ready_w;
  logic       wr_fire;
  logic       wr_close;
  logic       reuse_w;
  logic [1:0] full_cnt_w;

`ifdef WBUF_REUSE_EN
  assign reuse_w = bus.rd_reuse;
`else
  assign reuse_w = 1'b0;
`endif

  assign wr_ready_w = (bank_q[fill_sel_q] == B_EMPTY) || (bank_q[fill_sel_q] == B_FILLING);
  assign wr_fire    = bus.wr_en && wr_ready_w;
  // Implicit close when the bank's last slot is written.
  assign wr_close   = wr_fire && (bus.wr_last || (wptr_q == PTR_W'(DEPTH - 1)));

  always_comb begin
    full_cnt_w = 2'd0;
    for (int b = 0; b < 2; b++) begin
      if ((bank_q[b] == B_FULL) || (bank_q[b] == B_DRAINING)) begin
        full_cnt_w = full_cnt_w + 2'd1;
      end
    end
  end

  // Fill and drain always address different banks, so their updates to
  // bank_d/len_d never collide and both apply in the same cycle.
  always_comb begin
    bank_d      = bank_q;
    len_d       = len_q;
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    rd_st_d     = rd_st_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    rd_last_d   = rd_last_q;

    if (wr_fire) begin
      if (wr_close) begin
        bank_d[fill_sel_q] = B_FULL;
        len_d[fill_sel_q]  = LEN_W'(wptr_q) + LEN_W'(1);
        fill_sel_d         = ~fill_sel_q;
        wptr_d             = '0;
      end else begin
        bank_d[fill_sel_q] = B_FILLING;
        wptr_d             = wptr_q + PTR_W'(1);
      end
    end

    if (rd_st_q == RD_IDLE) begin
      if (bus.rd_start && (bank_q[drain_sel_q] == B_FULL)) begin
        bank_d[drain_sel_q] = B_DRAINING;
        rptr_d              = '0;
        rd_st_d             = RD_STREAM;
      end
    end else begin
      if (!rd_valid_q) begin
        // First stream cycle: load word 0 into the output register.
        rd_data_d  = mem_q[drain_sel_q][rptr_q];
        rd_valid_d = 1'b1;
        rd_last_d  = (len_q[drain_sel_q] == LEN_W'(1));
      end else if (!bus.rd_hold) begin
        if (rd_last_q) begin
          bank_d[drain_sel_q] = reuse_w ? B_FULL : B_EMPTY;
          drain_sel_d         = reuse_w ? drain_sel_q : ~drain_sel_q;
          rptr_d              = '0;
          rd_st_d             = RD_IDLE;
          rd_valid_d          = 1'b0;
          rd_last_d           = 1'b0;
        end else begin
          rptr_d    = rptr_q + PTR_W'(1);
          rd_data_d = mem_q[drain_sel_q][rptr_q + PTR_W'(1)];
          rd_last_d = ((LEN_W'(rptr_q) + LEN_W'(2)) == len_q[drain_sel_q]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int b = 0; b < 2; b++) begin
        bank_q[b] <= B_EMPTY;
        len_q[b]  <= '0;
      end
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_st_q     <= RD_IDLE;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      len_q       <= len_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      rd_st_q     <= rd_st_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  // Weight storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[fill_sel_q][wptr_q] <= bus.wr_data;
    end
  end

  assign bus.wr_ready = wr_ready_w;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_last  = rd_last_q;
  assign bus.full_cnt = full_cnt_w;
endmodule
